// File: rtl/ssriscv_ifu.sv
// Instruction fetch unit for a single-issue RISC-V core: fetches one word at a
// time, hands it to decode, then waits for the resolved next PC before fetching again.
module ssriscv_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic [31:0] pc_next,
  input  logic        pc_next_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_EXEC = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [31:0] r_fetch_count;
  logic        r_req_valid;
  logic        r_inst_valid;
  logic        r_misalign;

  wire w_pc_next_aligned = (pc_next[1:0] == 2'b00);

  // NOTE: every piece of state, including the handshake outputs, is assigned with <=
  // in this one block so all of it updates together on the edge and no output is
  // ever derived from a half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_inst        <= 32'h0;
      r_inst_pc     <= 32'h0;
      r_fetch_count <= 32'h0;
      r_req_valid   <= 1'b1;
      r_inst_valid  <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          // Request and address stay put until the memory takes them.
          if (imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            r_inst       <= imem_resp_data;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            r_fetch_count <= r_fetch_count + 32'd1;
            r_inst_valid  <= 1'b0;
            r_state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (pc_next_valid) begin
            r_pc <= pc_next;
            if (w_pc_next_aligned) begin
              r_req_valid <= 1'b1;
              r_state     <= S_REQ;
            end else begin
              r_misalign <= 1'b1;
              r_state    <= S_ERR;
            end
          end
        end
        S_ERR: begin
          // Terminal until reset; the faulting PC stays visible on imem_req_addr.
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_ERR;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign misalign_err   = r_misalign;
  assign fetch_count    = r_fetch_count;

endmodule

// File: doc/ssriscv_ifu.md
SSRISCV_IFU -- requirements
Module: ssriscv_ifu

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word-aligned PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_req_addr  output  32  fetch address, equals current PC.
REQ-007 imem_resp_valid  input  1  instruction word returned this cycle.
REQ-008 imem_resp_data  input  32  returned instruction word.
REQ-009 inst_valid  output  1  fetched instruction available to decode/execute.
REQ-010 inst_ready  input  1  decode/execute accepts instruction.
REQ-011 inst  output  32  held instruction word.
REQ-012 inst_pc  output  32  PC of held instruction.
REQ-013 pc_next  input  32  next PC from the next-PC adder (jal/jalr/branch/+4 already resolved).
REQ-014 pc_next_valid  input  1  pc_next valid; accepted instruction has completed.
REQ-015 misalign_err  output  1  sticky: pc_next not word-aligned.
REQ-016 fetch_count  output  32  number of instructions handed to decode.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, EXEC, ERR; exactly one active.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready=1 -> WAIT; else stay with addr stable.
REQ-019 WAIT: imem_req_valid=0; on imem_resp_valid=1 capture imem_resp_data into inst and pc into inst_pc -> HOLD.
REQ-020 HOLD: inst_valid=1, inst/inst_pc stable; on inst_ready=1 -> EXEC, fetch_count increments by 1 (wraps 32'hFFFF_FFFF -> 0).
REQ-021 EXEC: inst_valid=0, no request; on pc_next_valid=1 pc<=pc_next; if pc_next[1:0]==2'b00 -> REQ, else -> ERR.
REQ-022 ERR: misalign_err=1, imem_req_valid=0, inst_valid=0; pc holds the faulting pc_next; exit only by rst.
REQ-023 Memory response latency SHALL be >=1 cycle after request acceptance; imem_resp_valid in REQ, HOLD, EXEC or ERR SHALL be ignored.
REQ-024 pc_next_valid outside EXEC SHALL be ignored; inst_ready outside HOLD SHALL be ignored.
REQ-025 imem_req_valid, once asserted, SHALL stay asserted with constant address until accepted.
REQ-026 Minimum loop: REQ->WAIT->HOLD->EXEC->REQ = 4 cycles per instruction with zero stalls and 1-cycle memory latency.
REQ-027 imem_req_addr and inst_pc SHALL always be word-aligned outside ERR.

Reset
REQ-028 On rst=1 at a rising edge: state=REQ, pc=RESET_PC, inst=0, inst_pc=0, fetch_count=0, misalign_err=0, inst_valid=0; imem_req_valid=1 from the first cycle after rst deasserts.
REQ-029 rst SHALL take priority over every other input in any state, including mid-WAIT and ERR.
REQ-030 Instruction memory shares rst and SHALL discard outstanding responses; the IFU need not filter stale responses.

Verification
REQ-031 Reset release, imem_req_ready=1, response 1 cycle later 32'h0000_0013, inst_ready=1, pc_next=32'h4 -> first req addr 0, inst=0x13, inst_pc=0, fetch_count=1, second req addr 0x4 four cycles after first.
REQ-032 imem_req_ready held 0 for 3 cycles -> imem_req_valid stays 1, addr constant; WAIT entered only after ready.
REQ-033 inst_ready held 0 for 5 cycles in HOLD, spurious pc_next_valid and imem_resp_valid pulses -> inst/inst_pc unchanged, fetch_count unchanged, no new request.
REQ-034 Jump: in EXEC pc_next=32'h0000_0100 -> next imem_req_addr=0x100; pc_next=32'h0000_0102 -> misalign_err=1, no further requests, recovered only by rst.
REQ-035 rst asserted mid-WAIT with pc=0x40 -> next cycle state REQ, addr=RESET_PC, fetch_count=0, misalign_err=0.
REQ-036 Force fetch_count to 32'hFFFF_FFFF then one handoff -> fetch_count=0.
